// File: rtl/dma_seq_pkg.sv
// Shared definitions for the AM2940 DMA sequencer: FSM states and
// the AM2940 instruction codes driven onto its Instruction pins.
package dma_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CTRL,
    ST_LD_ADDR,
    ST_LD_WC,
    ST_XFER,
    ST_ADV,
    ST_CHECK,
    ST_FIN
  } state_e;

  localparam logic [2:0] I_WR_CTRL = 3'b000;
  localparam logic [2:0] I_RD_CTRL = 3'b001;
  localparam logic [2:0] I_RD_WC   = 3'b010;
  localparam logic [2:0] I_RD_AC   = 3'b011;
  localparam logic [2:0] I_REINIT  = 3'b100;
  localparam logic [2:0] I_LD_ADDR = 3'b101;
  localparam logic [2:0] I_LD_WC   = 3'b110;
  localparam logic [2:0] I_ENABLE  = 3'b111;

endpackage

// File: rtl/dma_sequencer.sv
// Programs an AM2940 (control, address, word count) on start, then steps its
// counters once per acknowledged memory word until the AM2940 reports Done.
module dma_sequencer
  import dma_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_count,
  input  logic [2:0]        cfg_ctrl,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic              Done,
  output logic [2:0]        Instruction,
  output logic [DATA_W-1:0] DataInput,
  output logic              ACI,
  output logic              WCI,
  output logic              busy,
  output logic              xfer_done,
  output logic [DATA_W-1:0] words_moved
);

  state_e state_q, state_d;

  logic [DATA_W-1:0] addr_q, count_q;
  logic [DATA_W-1:0] words_q, words_d;

  logic [2:0]        instr_q, instr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              aci_q, aci_d;
  logic              wci_q, wci_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic accept;

  assign accept = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (start) state_d = ST_WR_CTRL;
    end else if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_WR_CTRL: state_d = ST_LD_ADDR;
        ST_LD_ADDR: state_d = ST_LD_WC;
        ST_LD_WC:   state_d = ST_XFER;
        ST_XFER:    if (mem_ack) state_d = ST_ADV;
        ST_ADV:     state_d = ST_CHECK;
        ST_CHECK:   state_d = Done ? ST_FIN : ST_XFER;
        ST_FIN:     state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so each pin
  // shows the value belonging to the state the FSM is in this cycle.
  always_comb begin
    instr_d = I_RD_CTRL;
    din_d   = '0;
    aci_d   = 1'b1;
    wci_d   = 1'b1;
    req_d   = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = 1'b0;
    case (state_d)
      ST_WR_CTRL: begin
        instr_d = I_WR_CTRL;
        // Only ever entered on the accepting edge, so the live input is the captured value.
        din_d   = {{(DATA_W-3){1'b0}}, cfg_ctrl};
      end
      ST_LD_ADDR: begin
        instr_d = I_LD_ADDR;
        din_d   = addr_q;
      end
      ST_LD_WC: begin
        instr_d = I_LD_WC;
        din_d   = count_q;
      end
      ST_XFER: begin
        instr_d = I_ENABLE;
        req_d   = 1'b1;
      end
      ST_ADV: begin
        instr_d = I_ENABLE;
        aci_d   = 1'b0;
        wci_d   = 1'b0;
      end
      ST_CHECK: instr_d = I_ENABLE;
      ST_FIN:   done_d  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    words_d = words_q;
    if (accept) words_d = '0;
    else if (state_d == ST_ADV) words_d = words_q + DATA_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      words_q <= '0;
      instr_q <= I_RD_CTRL;
      din_q   <= '0;
      aci_q   <= 1'b1;
      wci_q   <= 1'b1;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      instr_q <= instr_d;
      din_q   <= din_d;
      aci_q   <= aci_d;
      wci_q   <= wci_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= cfg_addr;
      count_q <= cfg_count;
    end
  end

  assign Instruction = instr_q;
  assign DataInput   = din_q;
  assign ACI         = aci_q;
  assign WCI         = wci_q;
  assign mem_req     = req_q;
  assign busy        = busy_q;
  assign xfer_done   = done_q;
  assign words_moved = words_q;

endmodule

// File: tb/tb_dma_sequencer.sv
// Directed bench for dma_sequencer with a minimal AM2940 word-counter model
// and a memory responder whose ack latency is set per scenario.
module tb_dma_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort, mem_ack;
  logic       Done;
  logic [7:0] cfg_addr, cfg_count;
  logic [2:0] cfg_ctrl;
  logic       mem_req, ACI, WCI, busy, xfer_done;
  logic [2:0] Instruction;
  logic [7:0] DataInput, words_moved;

  int total = 0;
  int bad   = 0;

  int   ack_delay = 0;
  int   ack_cnt   = 0;
  logic done_force = 1'b0;
  logic [7:0] wc_m = 8'h00;

  dma_sequencer #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_addr(cfg_addr), .cfg_count(cfg_count), .cfg_ctrl(cfg_ctrl),
    .mem_req(mem_req), .mem_ack(mem_ack), .Done(Done),
    .Instruction(Instruction), .DataInput(DataInput), .ACI(ACI), .WCI(WCI),
    .busy(busy), .xfer_done(xfer_done), .words_moved(words_moved)
  );

  always #5 clk = ~clk;

  // AM2940 word counter: loaded by LD_WC, decremented on WCI low while enabled.
  always @(posedge clk) begin
    if (Instruction == 3'b110) wc_m <= DataInput;
    else if (Instruction == 3'b111 && !WCI) wc_m <= wc_m - 8'd1;
  end
  assign Done = done_force | (wc_m == 8'h00);

  // Memory: ack after ack_delay cycles of mem_req, reset when mem_req drops.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (ack_cnt >= ack_delay) mem_ack = 1'b1;
      else begin
        ack_cnt++;
        mem_ack = 1'b0;
      end
    end else begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end
  end

  task automatic wait_xfer_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (xfer_done) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: xfer_done got 0 within 200 cycles, wanted 1", name);
    end
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [2:0] c, input logic [7:0] a, input logic [7:0] n);
    cfg_ctrl = c; cfg_addr = a; cfg_count = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_ctrl = 3'b111; cfg_addr = 8'hFF; cfg_count = 8'hEE;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (Instruction !== 3'b001) begin bad++; $display("FAIL reset_instr: got %b want 001", Instruction); end
    total++; if (ACI !== 1'b1 || WCI !== 1'b1) begin bad++; $display("FAIL reset_ci: got ACI=%b WCI=%b want 1 1", ACI, WCI); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
    total++; if (words_moved !== 8'd0) begin bad++; $display("FAIL reset_words: got %0d want 0", words_moved); end
    total++; if (DataInput !== 8'h00 || xfer_done !== 1'b0) begin bad++; $display("FAIL reset_din_done: got %h/%b want 00/0", DataInput, xfer_done); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_program_and_transfer;
    int adv = 0;
    int pulses = 0;
    bit fin = 0;
    ack_delay = 0;
    pulse_start(3'b000, 8'h40, 8'h04);
    total++; if (Instruction !== 3'b000 || DataInput !== 8'h00 || busy !== 1'b1) begin bad++; $display("FAIL prog_wrctrl: got %b/%h/%b want 000/00/1", Instruction, DataInput, busy); end
    @(negedge clk);
    total++; if (Instruction !== 3'b101 || DataInput !== 8'h40) begin bad++; $display("FAIL prog_ldaddr: got %b/%h want 101/40", Instruction, DataInput); end
    @(negedge clk);
    total++; if (Instruction !== 3'b110 || DataInput !== 8'h04) begin bad++; $display("FAIL prog_ldwc: got %b/%h want 110/04", Instruction, DataInput); end
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || Instruction !== 3'b111) begin bad++; $display("FAIL prog_req: got req=%b instr=%b want 1/111", mem_req, Instruction); end
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge clk);
      if (ACI === 1'b0 && WCI === 1'b0) adv++;
      if (xfer_done === 1'b1) begin pulses++; fin = 1; end
    end
    @(negedge clk);
    if (xfer_done === 1'b1) pulses++;
    total++; if (adv != 4) begin bad++; $display("FAIL xfer_adv: got %0d ADV cycles want 4", adv); end
    total++; if (pulses != 1) begin bad++; $display("FAIL xfer_pulses: got %0d xfer_done pulses want 1", pulses); end
    total++; if (words_moved !== 8'd4) begin bad++; $display("FAIL xfer_words: got %0d want 4", words_moved); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL xfer_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_stall;
    int high = 0;
    bit stop = 0;
    bit ci_ok = 1;
    bit wm_ok = 1;
    ack_delay = 5;
    pulse_start(3'b000, 8'h10, 8'h02);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20 && !stop; i++) begin
      if (mem_req === 1'b1) begin
        high++;
        if (ACI !== 1'b1 || WCI !== 1'b1) ci_ok = 0;
        if (words_moved !== 8'd0) wm_ok = 0;
        @(negedge clk);
      end else stop = 1;
    end
    total++; if (high != 6) begin bad++; $display("FAIL stall_req: mem_req high %0d cycles want 6", high); end
    total++; if (!ci_ok) begin bad++; $display("FAIL stall_ci: ACI/WCI got 0 while stalled want 1"); end
    total++; if (!wm_ok) begin bad++; $display("FAIL stall_words: words_moved changed before ack, want 0"); end
    total++; if (words_moved !== 8'd1 || ACI !== 1'b0) begin bad++; $display("FAIL stall_adv: got words=%0d ACI=%b want 1/0", words_moved, ACI); end
    ack_delay = 0;
    wait_xfer_done("stall_finish");
  endtask

  task automatic test_abort;
    bit hit = 0;
    bit nodone = 1;
    ack_delay = 0;
    pulse_start(3'b000, 8'h80, 8'h08);
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (words_moved === 8'd1) hit = 1;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (Instruction !== 3'b111 || busy !== 1'b1 || words_moved !== 8'd1) begin bad++; $display("FAIL abort_start_ignored: got %b/%b/%0d want 111/1/1", Instruction, busy, words_moved); end
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (words_moved === 8'd2 && mem_req === 1'b1) hit = 1;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (busy !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL abort_idle: got busy=%b req=%b want 0/0", busy, mem_req); end
    total++; if (words_moved !== 8'd2) begin bad++; $display("FAIL abort_words: got %0d want 2", words_moved); end
    if (xfer_done !== 1'b0) nodone = 0;
    repeat (3) begin
      @(negedge clk);
      if (xfer_done !== 1'b0) nodone = 0;
    end
    total++; if (!nodone) begin bad++; $display("FAIL abort_nodone: xfer_done got 1 want 0"); end
  endtask

  task automatic test_reset_mid;
    ack_delay = 3;
    pulse_start(3'b000, 8'h22, 8'h01);
    repeat (3) @(negedge clk);
    done_force = 1'b1;
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL done_ignored: got req=%b busy=%b want 1/1", mem_req, busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0 || mem_req !== 1'b0 || Instruction !== 3'b001 || ACI !== 1'b1 || WCI !== 1'b1 || DataInput !== 8'h00 || xfer_done !== 1'b0)
      begin bad++; $display("FAIL midreset_outs: got busy=%b req=%b instr=%b aci=%b wci=%b din=%h done=%b want 0 0 001 1 1 00 0", busy, mem_req, Instruction, ACI, WCI, DataInput, xfer_done); end
    total++; if (words_moved !== 8'd0) begin bad++; $display("FAIL midreset_words: got %0d want 0", words_moved); end
    done_force = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    pulse_start(3'b001, 8'h33, 8'h01);
    total++; if (Instruction !== 3'b000 || DataInput !== 8'h01) begin bad++; $display("FAIL restart_wrctrl: got %b/%h want 000/01", Instruction, DataInput); end
    @(negedge clk);
    total++; if (Instruction !== 3'b101 || DataInput !== 8'h33) begin bad++; $display("FAIL restart_ldaddr: got %b/%h want 101/33", Instruction, DataInput); end
    wait_xfer_done("restart_finish");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; mem_ack = 1'b0;
    cfg_addr = '0; cfg_count = '0; cfg_ctrl = '0;
    test_reset();
    test_program_and_transfer();
    test_stall();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_sequencer.md
# dma_sequencer

Upstream controller for the AM2940 DMA address generator. On a start pulse it programs the AM2940 in three cycles: control register, address, then word count. It then runs a word-by-word memory handshake, advancing the AM2940 counters once per acknowledged word, until the AM2940 `Done` flag ends the transfer. Outputs drive the AM2940 `Instruction`, `DataInput`, `ACI` and `WCI` pins directly; `Done` is fed back as an input.

## Interface
- `DATA_W`, 8, width of address, word-count and DataInput paths.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin transfer; sampled only in IDLE.
- `abort`  in  1  terminate transfer; sampled in every non-IDLE state.
- `cfg_addr`  in  DATA_W  start address.
- `cfg_count`  in  DATA_W  word count.
- `cfg_ctrl`  in  3  AM2940 control word: [2] count direction, [1:0] Done mode.
- `mem_req`  out  1  memory word request.
- `mem_ack`  in  1  memory word acknowledge.
- `Done`  in  1  from AM2940.
- `Instruction`  out  3  to AM2940.
- `DataInput`  out  DATA_W  to AM2940.
- `ACI`  out  1  to AM2940 address counter carry-in, active-low (0 = advance).
- `WCI`  out  1  to AM2940 word counter carry-in, active-low (0 = advance).
- `busy`  out  1  high in every state except IDLE.
- `xfer_done`  out  1  one-cycle pulse on normal completion.
- `words_moved`  out  DATA_W  count of acknowledged words in current/last transfer.

## Operation
- All outputs are registered, Moore-decoded from state.
- The `cfg_*` inputs are captured into shadow registers on the accepted `start`, so they may change afterwards.
- States and transitions:
  - IDLE → WR_CTRL on `start`.
  - WR_CTRL: `Instruction`=000, `DataInput`={0…,cfg_ctrl}. → LD_ADDR.
  - LD_ADDR: `Instruction`=101, `DataInput`=cfg_addr. → LD_WC.
  - LD_WC: `Instruction`=110, `DataInput`=cfg_count. → XFER.
  - XFER: `Instruction`=111, `mem_req`=1, `ACI`=`WCI`=1. → ADV when `mem_ack`=1; otherwise hold, with no timeout.
  - ADV: `Instruction`=111, `mem_req`=0, `ACI`=`WCI`=0 for exactly one cycle; `words_moved` increments. → CHECK.
  - CHECK: `Instruction`=111, `ACI`=`WCI`=1. Samples `Done`: 1 → FIN, 0 → XFER.
  - FIN: `xfer_done`=1. → IDLE.
- IDLE outputs: `Instruction`=001 (read control, harmless), `DataInput`=0, `ACI`=`WCI`=1, `mem_req`=0.
- `abort` in any non-IDLE state → IDLE next cycle. It has priority over `mem_ack` and `Done`. No `xfer_done` pulse; `words_moved` keeps its value.
- `start` while busy: ignored.
- `words_moved` clears to 0 on an accepted `start` and wraps modulo 2^DATA_W.
- `Done` is sampled only in CHECK. Its level in other states is ignored, so every transfer moves at least one word, even if `cfg_count`=0.
- `mem_ack` is ignored outside XFER. An ack arriving in ADV or CHECK is not counted.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `mem_req`=0, `ACI`=`WCI`=1.
  - `Instruction`=001, `DataInput`=0, `xfer_done`=0, `words_moved`=0.
- Start latency: `start` high at edge N makes WR_CTRL visible after edge N; LD_ADDR follows after N+1, LD_WC after N+2, and `mem_req`=1 after N+3.
- Per-word cost: 3 cycles minimum (XFER with immediate ack, ADV, CHECK).
- `mem_req` holds high until the edge that samples `mem_ack`=1, and is low for at least 2 cycles between words.
- Completion: `xfer_done` is high one cycle after the CHECK that saw `Done`=1; `busy` drops the cycle after that.
- Reset mid-transfer: all outputs return to reset values after the next edge. The AM2940 state is left as-is and is reprogrammed on the next `start`.

## Structure
- Shared package `dma_seq_pkg` holds:
  - state enum (IDLE, WR_CTRL, LD_ADDR, LD_WC, XFER, ADV, CHECK, FIN);
  - AM2940 instruction code constants (WR_CTRL=000, RD_CTRL=001, RD_WC=010, RD_AC=011, REINIT=100, LD_ADDR=101, LD_WC=110, ENABLE=111).
- Single module; no sub-module. The FSM, shadow registers and `words_moved` counter are inline.
- Top-level integration instantiates `dma_sequencer` beside `AM2940`, with `Instruction`/`DataInput`/`ACI`/`WCI`/`Done` wired point-to-point.

## Test plan
- Reset then idle: hold `reset` 2 cycles → `Instruction`=001, `ACI`=`WCI`=1, `busy`=0, `mem_req`=0, `words_moved`=0.
- Programming sequence: `start` with cfg_ctrl=3'b000, cfg_addr=8'h40, cfg_count=8'h04 → `Instruction` 000/101/110 with `DataInput` 00/40/04 on three consecutive cycles, then `mem_req`=1.
- Full transfer against an AM2940 model with ack on the first XFER cycle each time → exactly one ADV (`ACI`=`WCI`=0) per word; `words_moved`=4; `xfer_done` pulses once when `Done` goes high.
- Stalled memory: delay `mem_ack` 5 cycles → `mem_req` stays high 6 cycles, `ACI`/`WCI` stay 1, and `words_moved` is unchanged until ack.
- Abort in XFER after 2 words → IDLE next cycle, `mem_req`=0, no `xfer_done`, `words_moved`=2; a `start` during the transfer has no effect.
- Mid-transfer `reset` with `Done` forced high in XFER → all outputs at reset values, no `xfer_done`; a following `start` reprograms from WR_CTRL.
